i_pkt_arbiter: RTL

Packet-granular arbiter and steering controller for an N-input interconnect merge datapath.
- Chooses one requester per packet and holds the grant from the header beat through the TLAST beat.
- Drives the merge's input-select and per-port TREADY qualification.
- Replaces fixed port-0 priority with selectable round-robin or fixed priority, and reports per-beat and per-packet events for the merge and for debug.

---
 rtl/i_pkt_arbiter_if.sv | 26 ++
 rtl/i_pkt_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/i_pkt_arbiter_if.sv
// Request/steering bundle between N merge input ports and the packet arbiter.
// master drives requests and storage ready; slave (the arbiter) returns grant, select and events.
interface i_pkt_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = 3
);
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic           out_ready;
  logic [N-1:0]   grant;
  logic [IDW-1:0] sel;
  logic           hdr;
  logic           beat;
  logic           pkt_done;
  logic           err;

  modport master (
    output req_valid, req_last, out_ready,
    input  grant, sel, hdr, beat, pkt_done, err
  );

  modport slave (
    input  req_valid, req_last, out_ready,
    output grant, sel, hdr, beat, pkt_done, err
  );
endinterface

// File: rtl/i_pkt_arbiter.sv
// Packet-granular N-input arbiter: grant held header..TLAST, round-robin or fixed priority.
// Optional stall watchdog enabled by defining I_PKT_ARBITER_TIMEOUT_EN.
module i_pkt_arbiter #(
  parameter int N       = 4,
  parameter int IDW     = 3,
  parameter int RR      = 1,
  parameter int TIMEOUT = 255
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  i_pkt_arbiter_if.slave bus
);
  localparam int W = 1 << IDW;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PKT  = 1'b1
  } state_t;

  if (N < 1 || N > 8 || W < N || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_cfg
    $error("i_pkt_arbiter: illegal parameter combination");
  end

  state_t         r_state;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] r_cur;
  logic           r_pkt_done;

  logic [W-1:0]   w_vld_pad;
  logic [W-1:0]   w_last_pad;
  logic [IDW-1:0] w_base;
  logic [IDW-1:0] w_win;
  logic [IDW-1:0] w_sel;
  logic           w_any;
  logic           w_beat;
  logic           w_last;
  logic [N-1:0]   w_grant;

  // base and off are both below N, so one subtraction wraps correctly.
  function automatic logic [IDW-1:0] idx_wrap(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return IDW'(s);
  endfunction

  assign w_vld_pad  = W'(bus.req_valid);
  assign w_last_pad = W'(bus.req_last);
  assign w_base     = (RR != 0) ? r_rr_ptr : '0;

  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_any && w_vld_pad[idx_wrap(w_base, i)]) begin
        w_win = idx_wrap(w_base, i);
        w_any = 1'b1;
      end
    end
  end

  assign w_sel = (r_state == S_PKT) ? r_cur : w_win;

  always_comb begin
    w_grant = '0;
    if ((r_state == S_PKT) || w_any) begin
      for (int i = 0; i < N; i++) begin
        w_grant[i] = (w_sel == IDW'(i));
      end
    end
  end

  assign w_beat = bus.out_ready && w_vld_pad[w_sel] && (|w_grant);
  assign w_last = w_last_pad[w_sel];

`ifdef I_PKT_ARBITER_TIMEOUT_EN
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] r_wdog;
  logic        r_err;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_cur      <= '0;
      r_pkt_done <= 1'b0;
      r_err      <= 1'b0;
      r_wdog     <= '0;
    end else begin
      r_pkt_done <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_beat) begin
            if (w_last) begin
              r_pkt_done <= 1'b1;
              r_rr_ptr   <= idx_wrap(w_win, 1);
            end else begin
              r_cur   <= w_win;
              r_wdog  <= '0;
              r_state <= S_PKT;
            end
          end
        end
        S_PKT: begin
          if (w_beat) begin
            r_wdog <= '0;
            if (w_last) begin
              r_pkt_done <= 1'b1;
              r_rr_ptr   <= idx_wrap(r_cur, 1);
              r_state    <= S_IDLE;
            end
          end else if (r_wdog == WD_LIMIT) begin
            // Abort: the stalled packet releases the merge without a pkt_done.
            r_err    <= 1'b1;
            r_rr_ptr <= idx_wrap(r_cur, 1);
            r_wdog   <= '0;
            r_state  <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.err = r_err;
`else
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_cur      <= '0;
      r_pkt_done <= 1'b0;
    end else begin
      r_pkt_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_beat) begin
            if (w_last) begin
              r_pkt_done <= 1'b1;
              r_rr_ptr   <= idx_wrap(w_win, 1);
            end else begin
              r_cur   <= w_win;
              r_state <= S_PKT;
            end
          end
        end
        S_PKT: begin
          if (w_beat && w_last) begin
            r_pkt_done <= 1'b1;
            r_rr_ptr   <= idx_wrap(r_cur, 1);
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.err = 1'b0;
`endif

  assign bus.grant    = w_grant;
  assign bus.sel      = w_sel;
  assign bus.hdr      = (r_state == S_IDLE);
  assign bus.beat     = w_beat;
  assign bus.pkt_done = r_pkt_done;
endmodule
